// File: rtl/cv32e40p_x_acc_stub.sv
// ---------------------------------------------------------------------------
// cv32e40p_x_acc_stub : x-interface accelerator (custom-0 ALU, result FIFO, xmem stores)
// Optional MUL via `define CV32E40P_X_ACC_MUL_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cv32e40p_x_acc_stub #(
  parameter int LATENCY   = 2,
  parameter int RES_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  output logic        x_ready_o,
  output logic        x_accept_o,
  input  logic [31:0] x_instr_i,
  input  logic [95:0] x_rs_i,
  input  logic [2:0]  x_rs_valid_i,
  input  logic        x_rd_clean_i,
  output logic        x_rvalid_o,
  input  logic        x_rready_i,
  output logic [4:0]  x_rwaddr_o,
  output logic [31:0] x_rdata_o,
  output logic        xmem_valid_o,
  input  logic        xmem_ready_i,
  output logic        xmem_we_o,
  output logic [31:0] xmem_addr_o,
  output logic [31:0] xmem_wdata_o,
  output logic        xmem_endoftransaction_o,
  output logic        xmem_instr_wb_o,
  input  logic        xmem_rvalid_i,
  output logic        xmem_rready_o
);

  localparam int            PW       = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int            CW       = $clog2(RES_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(RES_DEPTH - 1);
  localparam logic [2:0]    LAT_INIT = 3'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM_REQ, MEM_WAIT} state_t;
  typedef enum logic [1:0] {OP_ADD3, OP_XOR2, OP_MEMW, OP_MUL} op_t;

  state_t      state;
  op_t         op;
  op_t         dec_op;
  logic [2:0]  cnt;
  logic [31:0] rs1, rs2, rs3;
  logic [4:0]  rd;
  logic        legal, use_rs3, wb;
  logic        operands_ok, room, handshake, push, pop;
  logic [31:0] result;

  logic [4:0]    fifo_rd   [RES_DEPTH];
  logic [31:0]   fifo_data [RES_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic unused_instr;
  assign unused_instr = &{1'b0, x_instr_i[31:15]};

  always_comb begin
    legal   = 1'b0;
    dec_op  = OP_ADD3;
    use_rs3 = 1'b0;
    wb      = 1'b1;
    if (x_instr_i[6:0] == 7'b0001011) begin
      case (x_instr_i[14:12])
        3'b000: begin legal = 1'b1; use_rs3 = 1'b1; end
        3'b001: begin legal = 1'b1; dec_op = OP_XOR2; end
        3'b010: begin legal = 1'b1; dec_op = OP_MEMW; wb = 1'b0; end
`ifdef CV32E40P_X_ACC_MUL_EN
        3'b011: begin legal = 1'b1; dec_op = OP_MUL; end
`endif
        default: ;
      endcase
    end
  end

  // The in-flight term is zero whenever issue is possible (IDLE), kept for clarity of the rule.
  assign operands_ok = x_rs_valid_i[0] & x_rs_valid_i[1] & (~use_rs3 | x_rs_valid_i[2]);
  assign room        = ~wb | (x_rd_clean_i &
                       (({1'b0, count} + {{CW{1'b0}}, (state == EXEC)}) < (CW+1)'(RES_DEPTH)));
  assign x_ready_o   = ~legal | ((state == IDLE) & operands_ok & room);
  assign x_accept_o  = x_valid_i & legal;
  assign handshake   = x_valid_i & x_ready_o & x_accept_o;

  always_comb begin
    result = '0;
    case (op)
      OP_ADD3: result = rs1 + rs2 + rs3;
      OP_XOR2: result = rs1 ^ rs2;
`ifdef CV32E40P_X_ACC_MUL_EN
      OP_MUL:  result = rs1 * rs2;
`endif
      default: result = '0;
    endcase
  end

  assign push = (state == EXEC) && (cnt == 3'd0);
  assign pop  = x_rvalid_o & x_rready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      op    <= OP_ADD3;
      cnt   <= 3'd0;
      rs1   <= '0;
      rs2   <= '0;
      rs3   <= '0;
      rd    <= '0;
    end else begin
      case (state)
        IDLE: if (handshake) begin
          rs1 <= x_rs_i[31:0];
          rs2 <= x_rs_i[63:32];
          rs3 <= x_rs_i[95:64];
          rd  <= x_instr_i[11:7];
          op  <= dec_op;
          if (dec_op == OP_MEMW) begin
            state <= MEM_REQ;
          end else begin
            state <= EXEC;
            cnt   <= LAT_INIT;
          end
        end
        EXEC: begin
          if (cnt == 3'd0) state <= IDLE;
          else             cnt   <= cnt - 3'd1;
        end
        MEM_REQ:  if (xmem_ready_i)  state <= MEM_WAIT;
        MEM_WAIT: if (xmem_rvalid_i) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        fifo_rd[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_rd[wr_ptr]   <= rd;
        fifo_data[wr_ptr] <= result;
        wr_ptr            <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign x_rvalid_o              = (count != '0);
  assign x_rwaddr_o              = fifo_rd[rd_ptr];
  assign x_rdata_o               = fifo_data[rd_ptr];
  assign xmem_valid_o            = (state == MEM_REQ);
  assign xmem_we_o               = xmem_valid_o;
  assign xmem_endoftransaction_o = xmem_valid_o;
  assign xmem_addr_o             = rs1;
  assign xmem_wdata_o            = rs2;
  assign xmem_instr_wb_o         = (state == MEM_WAIT);
  assign xmem_rready_o           = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_cv32e40p_x_acc_stub.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_x_acc_stub : directed + randomized bench with an arithmetic reference model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cv32e40p_x_acc_stub;

  localparam int LAT   = 2;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid, x_ready, x_accept;
  logic [31:0] x_instr;
  logic [95:0] x_rs;
  logic [2:0]  x_rs_valid;
  logic        x_rd_clean, x_rvalid, x_rready;
  logic [4:0]  x_rwaddr;
  logic [31:0] x_rdata;
  logic        xmem_valid, xmem_ready, xmem_we, xmem_eot, xmem_instr_wb;
  logic [31:0] xmem_addr, xmem_wdata;
  logic        xmem_rvalid, xmem_rready;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];

  cv32e40p_x_acc_stub #(.LATENCY(LAT), .RES_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .x_valid_i(x_valid), .x_ready_o(x_ready), .x_accept_o(x_accept),
    .x_instr_i(x_instr), .x_rs_i(x_rs), .x_rs_valid_i(x_rs_valid), .x_rd_clean_i(x_rd_clean),
    .x_rvalid_o(x_rvalid), .x_rready_i(x_rready), .x_rwaddr_o(x_rwaddr), .x_rdata_o(x_rdata),
    .xmem_valid_o(xmem_valid), .xmem_ready_i(xmem_ready), .xmem_we_o(xmem_we),
    .xmem_addr_o(xmem_addr), .xmem_wdata_o(xmem_wdata), .xmem_endoftransaction_o(xmem_eot),
    .xmem_instr_wb_o(xmem_instr_wb), .xmem_rvalid_i(xmem_rvalid), .xmem_rready_o(xmem_rready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a, b, c);
    case (f3)
      3'b000:  return a + b + c;
      3'b001:  return a ^ b;
      default: return a * b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, b, c, input logic [2:0] rsv);
    logic [31:0] r;
    r          = $urandom();
    x_instr    = {r[31:15], f3, rd, opc};
    x_rs       = {c, b, a};
    x_rs_valid = rsv;
    x_valid    = 1'b1;
  endtask

  // Waits for issue handshake; leaves time at posedge+1 with x_valid dropped.
  task automatic wait_hs(input string tag);
    logic seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (x_ready && x_accept) begin seen = 1'b1; break; end
    end
    chk(tag, seen, 1'b1);
    @(posedge clk); #1;
    x_valid = 1'b0;
  endtask

  task automatic expect_result(input string tag, input int skip, input logic [4:0] rd, input logic [31:0] d);
    for (int k = skip; k < LAT; k++) begin
      @(negedge clk);
      chk({tag, "_early"}, x_rvalid, 1'b0);
    end
    @(negedge clk);
    chk({tag, "_rvalid"}, x_rvalid, 1'b1);
    chk({tag, "_rwaddr"}, x_rwaddr, rd);
    chk({tag, "_rdata"},  x_rdata,  d);
    @(posedge clk); #1;
  endtask

  task automatic run_alu(input string tag, input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] a, b, c);
    x_rready = 1'b1;
    drive(7'b0001011, f3, rd, a, b, c, 3'b111);
    wait_hs({tag, "_hs"});
    expect_result(tag, 0, rd, ref_alu(f3, a, b, c));
  endtask

  task automatic do_reject(input string tag, input logic [6:0] opc, input logic [2:0] f3);
    drive(opc, f3, 5'($urandom()), $urandom(), $urandom(), $urandom(), 3'b000);
    @(negedge clk);
    chk({tag, "_ready"},  x_ready,  1'b1);
    chk({tag, "_accept"}, x_accept, 1'b0);
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_rvalid"}, x_rvalid, 1'b0);
    chk({tag, "_xmem"},   xmem_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    logic seen;
    x_rready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [36:0] e;
      seen = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (x_rvalid) begin seen = 1'b1; break; end
      end
      chk({tag, "_valid"}, seen, 1'b1);
      if (!seen) begin exp_q.delete(); break; end
      e = exp_q.pop_front();
      chk({tag, "_rwaddr"}, x_rwaddr, e[36:32]);
      chk({tag, "_rdata"},  x_rdata,  e[31:0]);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk({tag, "_empty"}, x_rvalid, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a, b, c, a2, b2;
    logic [4:0]  rd, rd2, rd3;
    logic [2:0]  f3;

    rst = 1'b1; x_valid = 1'b0; x_instr = '0; x_rs = '0; x_rs_valid = '0;
    x_rd_clean = 1'b1; x_rready = 1'b1; xmem_ready = 1'b0; xmem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", x_rvalid, 1'b0);
    chk("rst_rwaddr", x_rwaddr, 5'd0);
    chk("rst_rdata",  x_rdata,  32'd0);
    chk("rst_xmem_valid", xmem_valid, 1'b0);
    chk("rst_instr_wb", xmem_instr_wb, 1'b0);
    chk("xmem_rready", xmem_rready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // ADD3 with wrap-around
    run_alu("add3_dir", 3'b000, 5'd5, 32'd1, 32'd2, 32'hFFFF_FFFF);

    // Illegal funct3 / opcode are turned away immediately
    do_reject("rej_f3_111", 7'b0001011, 3'b111);
    do_reject("rej_opcode", 7'b0101011, 3'b000);
`ifdef CV32E40P_X_ACC_MUL_EN
    run_alu("mul", 3'b011, 5'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);
`else
    do_reject("rej_mul", 7'b0001011, 3'b011);
`endif

    // Operand valid gating, then rd_clean gating
    rd = 5'd9; a = $urandom(); b = $urandom();
    drive(7'b0001011, 3'b001, rd, a, b, 32'd0, 3'b001);
    repeat (3) begin @(negedge clk); chk("rs_wait_ready", x_ready, 1'b0); end
    @(posedge clk); #1;
    x_rs_valid = 3'b011; x_rd_clean = 1'b0;
    @(negedge clk); chk("rd_dirty_ready", x_ready, 1'b0);
    @(posedge clk); #1;
    x_rd_clean = 1'b1;
    wait_hs("rs_valid_hs");
    expect_result("xor_rsv", 0, rd, a ^ b);

    // Reject accepted in any state: present one while EXEC is running
    a = $urandom(); b = $urandom(); c = $urandom(); rd = 5'd17;
    drive(7'b0001011, 3'b000, rd, a, b, c, 3'b111);
    wait_hs("busy_hs");
    drive(7'b0001011, 3'b110, 5'd3, 32'd0, 32'd0, 32'd0, 3'b000);
    @(negedge clk);
    chk("busy_rej_ready", x_ready, 1'b1);
    chk("busy_rej_accept", x_accept, 1'b0);
    @(posedge clk); #1;
    x_valid = 1'b0;
    expect_result("busy_add3", 1, rd, a + b + c);

    // Randomized mix of ALU ops and rejects
    for (int i = 0; i < 10; i++) begin
      int sel = $urandom_range(0, 3);
      a = $urandom(); b = $urandom(); c = $urandom(); rd = 5'($urandom());
      if (sel < 2) begin
        run_alu("rand_alu", 3'(sel), rd, a, b, c);
      end else if (sel == 2) begin
        f3 = 3'($urandom_range(4, 7));
        do_reject("rand_rej_f3", 7'b0001011, f3);
      end else begin
        do_reject("rand_rej_op", 7'b0001010, 3'b000);
      end
    end

    // Result FIFO full: third write-back waits for a pop, order preserved
    x_rready = 1'b0;
    rd = 5'd1; a = $urandom(); b = $urandom();
    drive(7'b0001011, 3'b001, rd, a, b, 32'd0, 3'b011);
    wait_hs("fifo_hs1");
    exp_q.push_back({rd, a ^ b});
    rd2 = 5'd2; a2 = $urandom(); b2 = $urandom();
    drive(7'b0001011, 3'b001, rd2, a2, b2, 32'd0, 3'b011);
    wait_hs("fifo_hs2");
    exp_q.push_back({rd2, a2 ^ b2});
    repeat (LAT + 1) @(posedge clk); #1;
    rd3 = 5'd3; a = $urandom(); b = $urandom();
    drive(7'b0001011, 3'b001, rd3, a, b, 32'd0, 3'b011);
    repeat (4) begin
      @(negedge clk);
      chk("fifo_full_ready", x_ready, 1'b0);
      chk("fifo_full_head", x_rwaddr, exp_q[0][36:32]);
    end
    @(posedge clk); #1;
    x_rready = 1'b1;
    @(negedge clk);
    chk("fifo_pop1_valid", x_rvalid, 1'b1);
    chk("fifo_pop1_data", x_rdata, exp_q[0][31:0]);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    x_rready = 1'b0;
    wait_hs("fifo_hs3");
    exp_q.push_back({rd3, a ^ b});
    drain("fifo_order");

    // Memory store with a stalled request channel
    x_rd_clean = 1'b0;
    drive(7'b0001011, 3'b010, 5'd4, 32'h100, 32'hAB, 32'd0, 3'b011);
    wait_hs("memw_hs");
    x_rd_clean = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("memw_valid", xmem_valid, 1'b1);
      chk("memw_we", xmem_we, 1'b1);
      chk("memw_addr", xmem_addr, 32'h100);
      chk("memw_wdata", xmem_wdata, 32'hAB);
      chk("memw_eot", xmem_eot, 1'b1);
      chk("memw_wb_early", xmem_instr_wb, 1'b0);
    end
    @(posedge clk); #1;
    xmem_ready = 1'b1;
    @(negedge clk); chk("memw_valid_at_ready", xmem_valid, 1'b1);
    @(posedge clk); #1;
    xmem_ready = 1'b0;
    @(negedge clk);
    chk("memw_valid_drop", xmem_valid, 1'b0);
    chk("memw_wb", xmem_instr_wb, 1'b1);
    @(posedge clk); #1;
    drive(7'b0001011, 3'b001, 5'd6, 32'd1, 32'd2, 32'd0, 3'b011);
    @(negedge clk);
    chk("memw_busy_ready", x_ready, 1'b0);
    chk("memw_wb_hold", xmem_instr_wb, 1'b1);
    @(posedge clk); #1;
    x_valid = 1'b0; xmem_rvalid = 1'b1;
    @(negedge clk); chk("memw_wb_at_rvalid", xmem_instr_wb, 1'b1);
    @(posedge clk); #1;
    xmem_rvalid = 1'b0;
    @(negedge clk);
    chk("memw_wb_clear", xmem_instr_wb, 1'b0);
    chk("memw_no_result", x_rvalid, 1'b0);
    @(posedge clk); #1;

    // Asynchronous reset during EXEC with one queued result
    x_rready = 1'b0;
    a = $urandom(); b = $urandom();
    drive(7'b0001011, 3'b001, 5'd10, a, b, 32'd0, 3'b011);
    wait_hs("rst_hs1");
    repeat (LAT + 1) @(posedge clk); #1;
    drive(7'b0001011, 3'b001, 5'd11, b, a, 32'd0, 3'b011);
    wait_hs("rst_hs2");
    #2 rst = 1'b1;
    #1;
    chk("arst_rvalid", x_rvalid, 1'b0);
    chk("arst_rwaddr", x_rwaddr, 5'd0);
    chk("arst_rdata", x_rdata, 32'd0);
    chk("arst_xmem_valid", xmem_valid, 1'b0);
    chk("arst_instr_wb", xmem_instr_wb, 1'b0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (LAT + 3) begin @(negedge clk); chk("arst_no_result", x_rvalid, 1'b0); end
    @(posedge clk); #1;
    run_alu("post_rst", 3'b000, 5'($urandom()), $urandom(), $urandom(), $urandom());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
